// File: rtl/lsram_stream_fifo.sv
// Stream FIFO on an external two-port LSRAM with 1-cycle read latency.
// A 2-entry output buffer hides the RAM latency for 1 word/cycle flow.
module lsram_stream_fifo #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  empty,
  output logic                  ram_awe,
  output logic [ADDR_WIDTH-1:0] ram_aaddr,
  output logic [DATA_WIDTH-1:0] ram_adin,
  output logic [ADDR_WIDTH-1:0] ram_baddr,
  input  logic [DATA_WIDTH-1:0] ram_bdout
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int LW = ADDR_WIDTH + 2;
  localparam logic [PW-1:0] DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] PONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OB_EMPTY,
    OB_ONE,
    OB_TWO
  } ob_state_t;

  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic [PW-1:0]         ram_cnt;
  logic                  inflight;
  ob_state_t             ob_q;
  ob_state_t             ob_d;
  logic [DATA_WIDTH-1:0] ob0_q;
  logic [DATA_WIDTH-1:0] ob1_q;
  logic [DATA_WIDTH-1:0] ob0_d;
  logic [DATA_WIDTH-1:0] ob1_d;
  logic [1:0]            ob_cnt;
  logic [2:0]            occ;
  logic                  wr;
  logic                  rd;
  logic                  pop;

  assign ram_cnt   = wp - rp;
  assign s_ready   = (ram_cnt < DEPTH) && !flush && aresetn;
  assign wr        = s_valid && s_ready;
  assign ram_awe   = wr;
  assign ram_aaddr = wp[ADDR_WIDTH-1:0];
  assign ram_adin  = s_data;
  assign ram_baddr = rp[ADDR_WIDTH-1:0];

  assign m_valid = (ob_q != OB_EMPTY);
  assign m_data  = ob0_q;
  assign pop     = m_valid && m_ready;

  assign occ = {1'b0, ob_cnt} + {2'b00, inflight}
             - {2'b00, pop};
  assign rd  = (ram_cnt != '0) && (occ < 3'd2);

  assign level = {1'b0, ram_cnt}
               + {{(LW-1){1'b0}}, inflight}
               + {{(LW-2){1'b0}}, ob_cnt};
  assign empty = (level == '0);

  // Output buffer occupancy derived from its state.
  always_comb begin
    ob_cnt = 2'd0;
    unique case (1'b1)
      ob_q == OB_ONE: ob_cnt = 2'd1;
      ob_q == OB_TWO: ob_cnt = 2'd2;
      default:        ob_cnt = 2'd0;
    endcase
  end

  // Output buffer next state: RAM data lands here when inflight.
  always_comb begin
    ob_d  = ob_q;
    ob0_d = ob0_q;
    ob1_d = ob1_q;
    unique case (ob_q)
      OB_EMPTY: begin
        if (inflight) begin
          ob_d  = OB_ONE;
          ob0_d = ram_bdout;
        end
      end
      OB_ONE: begin
        if (inflight && pop) begin
          ob0_d = ram_bdout;
        end else if (inflight) begin
          ob_d  = OB_TWO;
          ob1_d = ram_bdout;
        end else if (pop) begin
          ob_d = OB_EMPTY;
        end
      end
      OB_TWO: begin
        if (pop) begin
          ob0_d = ob1_q;
          if (inflight) ob1_d = ram_bdout;
          else          ob_d  = OB_ONE;
        end
      end
      default: ob_d = OB_EMPTY;
    endcase
  end

  // Pointers, read pipeline flag and buffer state; flush acts as reset.
  always_ff @(posedge aclk) begin
    if (!aresetn || flush) begin
      wp       <= '0;
      rp       <= '0;
      inflight <= 1'b0;
      ob_q     <= OB_EMPTY;
    end else begin
      if (wr) wp <= wp + PONE;
      if (rd) rp <= rp + PONE;
      inflight <= rd;
      ob_q     <= ob_d;
    end
  end

  // Buffer payload needs no reset; validity comes from ob_q.
  always_ff @(posedge aclk) begin
    ob0_q <= ob0_d;
    ob1_q <= ob1_d;
  end

endmodule

// File: doc/lsram_stream_fifo.md
LSRAM_STREAM_FIFO -- requirements
Module: lsram_stream_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 18, which is the word width and matches the attached LSRAM data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, which is the LSRAM address width; RAM depth is 2**ADDR_WIDTH.
REQ-003 The block SHALL have port aclk, input, 1 bit: the single clock; the attached LSRAM aclk and bclk are both tied to it.
REQ-004 The block SHALL have port aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous clear of all contents.
REQ-006 The block SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, DATA_WIDTH): the write stream.
REQ-007 The block SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, DATA_WIDTH): the read stream.
REQ-008 The block SHALL have ports level (output, ADDR_WIDTH+2) and empty (output, 1): the word count held and the level==0 flag.
REQ-009 The block SHALL have ports ram_awe (output, 1), ram_aaddr (output, ADDR_WIDTH) and ram_adin (output, DATA_WIDTH): the LSRAM two-port write side.
REQ-010 The block SHALL have ports ram_baddr (output, ADDR_WIDTH) and ram_bdout (input, DATA_WIDTH): the LSRAM two-port read side, which has registered output and 1-cycle latency.

Function
REQ-011 Write pointer wp and read pointer rp SHALL each be ADDR_WIDTH+1 bits, with ram_cnt = wp - rp (modulo 2**(ADDR_WIDTH+1)).
REQ-012 s_ready SHALL equal (ram_cnt < 2**ADDR_WIDTH) AND NOT flush AND aresetn, and SHALL be computed combinationally from registered state only.
REQ-013 When s_valid AND s_ready, then in the same cycle ram_awe=1, ram_aaddr=wp[ADDR_WIDTH-1:0] and ram_adin=s_data, and wp SHALL increment at the edge; otherwise ram_awe SHALL be 0.
REQ-014 ram_baddr SHALL always equal rp[ADDR_WIDTH-1:0].
REQ-015 A read SHALL issue in a cycle when ram_cnt>0 AND (obuf_cnt + inflight - pop) < 2, where pop = m_valid AND m_ready; on issue, rp SHALL increment and inflight SHALL be set to 1 for the next cycle.
REQ-016 In the cycle with inflight=1, ram_bdout SHALL be pushed into the output buffer; ram_bdout SHALL be ignored in all other cycles.
REQ-017 The output buffer SHALL be a 2-entry FIFO with states OB_EMPTY, OB_ONE and OB_TWO; push only moves state up, pop only moves state down, and push with pop holds state.
REQ-018 In OB_ONE and OB_TWO m_valid SHALL be 1 and m_data SHALL be the oldest entry; in OB_EMPTY m_valid SHALL be 0 and m_data SHALL be don't-care.
REQ-019 Once m_valid=1, m_valid SHALL stay 1 and m_data SHALL stay stable until pop.
REQ-020 level SHALL equal ram_cnt + inflight + obuf_cnt; its maximum is 2**ADDR_WIDTH+2. empty SHALL equal (level==0).
REQ-021 Latency SHALL be: a write handshake into an empty block at edge N gives m_valid=1 in the cycle after edge N+2.
REQ-022 Steady-state throughput SHALL be 1 word/cycle when s_valid=1 and m_ready=1 continuously.
REQ-023 Pointer wrap SHALL be natural modulo 2**(ADDR_WIDTH+1), and word order SHALL be preserved across wrap.
REQ-024 The read and write addresses SHALL never be equal in the same cycle, because a read needs ram_cnt>0 and a write needs ram_cnt<depth; if the addresses are equal, the block is either empty (no read) or full (no write).
REQ-025 A simultaneous write and pop at full SHALL be allowed only when s_ready=1; s_ready SHALL NOT depend combinationally on m_ready.
REQ-026 flush=1 at an edge SHALL clear wp, rp, inflight and the output buffer (OB_EMPTY); any write that cycle SHALL be suppressed (s_ready=0, ram_awe=0), and any in-flight read data SHALL be discarded.
REQ-027 RAM contents SHALL NOT need clearing on flush or reset.

Reset
REQ-028 While aresetn=0 at an edge, the block SHALL take the same effect as flush, with wp=rp=0, inflight=0 and OB_EMPTY.
REQ-029 Outputs SHALL take these values from the first edge with aresetn=0: s_ready=0 (held low while aresetn=0), m_valid=0, level=0, empty=1, ram_awe=0, ram_baddr=0.
REQ-030 A reset asserted mid-stream SHALL abandon all stored and in-flight words, and no stale word SHALL appear after reset release.

Verification
REQ-031 The bench SHALL cover: write 0x00001 at edge 0 into an empty block, m_ready=1 -> m_valid=1 with m_data=0x00001 after edge 2, and level goes 1,1,1 then 0 after the pop.
REQ-032 The bench SHALL cover: m_ready=0 with 1026 writes -> s_ready=0 after the 1024th RAM word plus 2 buffered words, with level=1026.
REQ-033 The bench SHALL cover: after the full case, 3000 words streamed with s_valid=m_ready=1 -> 1 word/cycle, pointers wrap, and output order equals input order.
REQ-034 The bench SHALL cover: random m_ready stalls with m_valid held -> m_data stable while m_valid=1 and m_ready=0.
REQ-035 The bench SHALL cover: flush asserted with level=5 and s_valid=1 -> the next cycle has level=0, m_valid=0 and no ram_awe pulse, and the first word afterward is the first word written post-flush.
REQ-036 The bench SHALL cover: aresetn=0 for 1 cycle with a read in flight -> the outputs in REQ-029 appear, and the discarded data never appears on m_data.
